i2s_rx_stereo: RTL and testbench
================================

# i2s_rx_stereo

Parametrised stereo I2S capture block: synchronises the external I2S_SCK/I2S_WS/I2S_SD pins into the CLK domain and deserialises MSB-first slots of arbitrary length. It supports Philips I2S (1-bit delay) and left-justified framing, pairs left/right slots into one frame and buffers frames in a small FIFO behind a valid/ready handshake. It sits between the codec pins and the audio sample pipeline, adding frame lock detection and overflow reporting.

## Interface
- SAMPLE_WIDTH, 24: bits kept per channel, 8..32.
- FIFO_DEPTH, 4: frame FIFO entries, power of two, >= 2.
- SYNC_STAGES, 2: synchroniser flops per pin, >= 2.
- CLK  in  1  system clock; one clock domain.
- RST  in  1  synchronous, active-high reset.
- I2S_SCK, I2S_WS, I2S_SD  in  1 each  asynchronous pins.
- enable  in  1  capture enable; low forces SEEK and clears overflow.
- mode  in  1  0 = Philips I2S, 1 = left-justified; change only while enable = 0.
- frame_left, frame_right  out  SAMPLE_WIDTH  FIFO head data.
- frame_valid  out  1  FIFO non-empty.
- frame_ready  in  1  consumer accepts head when frame_valid && frame_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- slot_bits  out  6  bit count of the last completed right slot, saturating at 63.
- locked  out  1  at least one valid frame committed since last SEEK.
- overflow  out  1  sticky; a frame was dropped because the FIFO was full.

## Operation
- Each pin passes through SYNC_STAGES flops. An SCK rising edge is detected when the synced SCK = 1 and its delayed copy = 0. ws_s and sd_s are sampled only in that cycle; the sampled pair is called a bit event.
- A slot boundary is a bit event where sampled WS differs from the WS of the previous bit event.
- Bit at the boundary event:
  - mode 0: belongs to the ending slot, as that slot's LSB.
  - mode 1: belongs to the new slot, as its MSB.
- Slot capture:
  - Per-slot bit counter, 6-bit, saturating at 63.
  - The first SAMPLE_WIDTH bits are shifted into the slot register MSB-first; later bits are ignored.
  - If a slot ends with count < SAMPLE_WIDTH, the value is left-aligned with zero LSBs.
- States:
  - SEEK (reset/enable low): on a 1→0 boundary, go to LEFT. The bit assigned to the new slot per mode is captured.
  - LEFT: on a 0→1 boundary, latch the left value and go to RIGHT.
  - RIGHT: on a 1→0 boundary, commit {left, right}, update slot_bits, set locked, and go to LEFT.
  - LEFT or RIGHT: a counter saturating at 63 means lost framing. Go to SEEK, clear locked, commit nothing.
- A partial frame captured before the first SEEK→LEFT transition is never committed.
- FIFO behaviour:
  - Push on commit; pop on frame_valid && frame_ready.
  - Push when full: frame dropped, overflow set, FIFO contents unchanged.
  - Simultaneous push and pop when full: both succeed, no overflow.
  - No bypass; an empty FIFO shows frame_valid the cycle after the push.
- enable = 0:
  - State goes to SEEK, locked = 0, overflow = 0.
  - FIFO keeps its contents and keeps draining.
- Reset values: frame_valid 0, frame_left/right 0, fifo_level 0, slot_bits 0, locked 0, overflow 0, state SEEK, synchronisers 0.

## Timing
- I2S_SCK must be ≤ CLK/4, with SCK high and low each ≥ 2 CLK periods.
- Pin edge to bit event: SYNC_STAGES CLK cycles.
- Right-slot boundary pin edge to frame_valid: SYNC_STAGES+1 cycles (3 for the default).
- State, counters and FIFO write are registered at the end of the bit-event cycle.
- RST wins over all other inputs in the same cycle. Mid-frame reset discards the partial frame and the FIFO contents.
- frame_left/right are stable while frame_valid && !frame_ready.

## Structure
- Package i2s_pkg holds:
  - mode constants I2S_MODE_PHILIPS = 0 and I2S_MODE_LJ = 1;
  - state encoding SEEK/LEFT/RIGHT;
  - the slot-count width constant (6).
- Sub-module i2s_frame_fifo: a synchronous FIFO, width 2*SAMPLE_WIDTH, depth FIFO_DEPTH, with level, full and empty outputs.
- Synchroniser, edge detect, slot FSM and shift registers sit in the top module.

## Test plan
- Philips mode, SAMPLE_WIDTH 24, 32-bit slots, left 0xA5A5A5, right 0x5A5A5A -> one frame, left 0xA5A5A5, right 0x5A5A5A, slot_bits 32, locked 1.
- Left-justified mode, 16-bit slots, left 0x1234, right 0xBEEF -> frame_left 0x123400, frame_right 0xBEEF00, slot_bits 16.
- frame_ready held 0, FIFO_DEPTH 4, 6 frames sent -> fifo_level 4, overflow 1, popped frames are frames 1-4 in order; enable low clears overflow.
- Capture starts mid right slot -> no frame until a full LEFT+RIGHT pair. A WS stuck for 70 SCKs -> locked 0, state SEEK, no commit.
- Full FIFO with frame_ready 1 in the exact commit cycle -> new frame accepted, level stays 4, overflow 0.
- RST asserted mid left slot with 2 frames queued -> next cycle frame_valid 0, level 0. The next complete frame after reset is captured correctly.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and types for the stereo I2S receiver.
// Holds framing mode codes, slot FSM encoding and slot counter helpers.
package i2s_pkg;

    localparam logic I2S_MODE_PHILIPS = 1'b0;
    localparam logic I2S_MODE_LJ      = 1'b1;

    localparam int SLOT_CNT_W = 6;
    localparam logic [SLOT_CNT_W-1:0] SLOT_CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

    // Slot bit counter increment that sticks at its maximum value.
    function automatic logic [SLOT_CNT_W-1:0] sat_inc(
        input logic [SLOT_CNT_W-1:0] c
    );
        return (c == SLOT_CNT_MAX) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/i2s_rx_stereo_if.sv
// Frame delivery bus between the I2S receiver and the sample consumer.
// master: frame_left/right, frame_valid, fifo_level out; frame_ready in.
interface i2s_rx_stereo_if #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int FIFO_DEPTH   = 4
);

    logic [SAMPLE_WIDTH-1:0]       frame_left;
    logic [SAMPLE_WIDTH-1:0]       frame_right;
    logic                          frame_valid;
    logic                          frame_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;

    modport master (
        output frame_left,
        output frame_right,
        output frame_valid,
        output fifo_level,
        input  frame_ready
    );

    modport slave (
        input  frame_left,
        input  frame_right,
        input  frame_valid,
        input  fifo_level,
        output frame_ready
    );

endinterface

// File: rtl/i2s_frame_fifo.sv
// Synchronous frame FIFO holding packed {left, right} stereo frames.
// Ports: clk, rst, push, pop, wdata, rdata, level, full, empty.
module i2s_frame_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem[rd_ptr];

    // A pop in the same cycle frees the slot the push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_rx_stereo.sv
// Stereo I2S capture: pin synchronisers, slot deserialiser, L/R framing FSM
// and frame FIFO. Ports: CLK, RST, I2S_SCK/WS/SD pins, enable, mode, frame
// bus (master), slot_bits, locked, overflow.
module i2s_rx_stereo
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 24,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   I2S_SCK,
    input  logic                   I2S_WS,
    input  logic                   I2S_SD,
    input  logic                   enable,
    input  logic                   mode,
    i2s_rx_stereo_if.master        frame,
    output logic [SLOT_CNT_W-1:0]  slot_bits,
    output logic                   locked,
    output logic                   overflow
);

    localparam int SW = SAMPLE_WIDTH;
    localparam logic [SW-1:0] TOP = {1'b1, {(SW-1){1'b0}}};

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ws_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   sck_d;
    logic                   sck_s;
    logic                   ws_s;
    logic                   sd_s;
    logic                   bit_evt;
    logic                   boundary;
    logic                   prev_ws;

    logic [SW-1:0]          sreg_q;
    logic [SW-1:0]          sreg_d;
    logic [SLOT_CNT_W-1:0]  cnt_q;
    logic [SLOT_CNT_W-1:0]  cnt_d;
    logic [SLOT_CNT_W-1:0]  cnt_inc;
    logic [SW-1:0]          mask;
    logic [SW-1:0]          with_bit;
    logic [SW-1:0]          end_val;
    logic [SLOT_CNT_W-1:0]  end_cnt;
    logic [SW-1:0]          left_q;

    rx_state_t              state_q;
    rx_state_t              state_d;
    logic                   commit;
    logic                   latch_left;
    logic                   lost;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic [2*SW-1:0]        fifo_rdata;

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign ws_s  = ws_sync[SYNC_STAGES-1];
    assign sd_s  = sd_sync[SYNC_STAGES-1];

    assign bit_evt  = sck_s && !sck_d;
    assign boundary = bit_evt && (ws_s != prev_ws);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_d    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], I2S_SCK};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], I2S_WS};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], I2S_SD};
            sck_d    <= sck_s;
        end
    end

    // Bit n of a slot lands at position SW-1-n; beyond SW the mask is
    // zero, so extra bits fall away and short slots stay left-aligned.
    always_comb begin
        mask     = TOP >> cnt_q;
        with_bit = sd_s ? (sreg_q | mask) : sreg_q;
        cnt_inc  = sat_inc(cnt_q);
        end_val  = with_bit;
        end_cnt  = cnt_inc;
        sreg_d   = with_bit;
        cnt_d    = cnt_inc;
        if (boundary) begin
            if (mode == I2S_MODE_LJ) begin
                // Boundary bit opens the new slot as its MSB.
                end_val = sreg_q;
                end_cnt = cnt_q;
                sreg_d  = sd_s ? TOP : '0;
                cnt_d   = SLOT_CNT_W'(1);
            end else begin
                // Boundary bit closes the old slot as its LSB.
                sreg_d = '0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= SEEK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        commit     = 1'b0;
        latch_left = 1'b0;
        lost       = 1'b0;
        if (!enable) begin
            state_d = SEEK;
        end else begin
            unique case (state_q)
                SEEK: begin
                    if (boundary && !ws_s) begin
                        state_d = LEFT;
                    end
                end
                LEFT: begin
                    if (cnt_q == SLOT_CNT_MAX) begin
                        state_d = SEEK;
                        lost    = 1'b1;
                    end else if (boundary && ws_s) begin
                        latch_left = 1'b1;
                        state_d    = RIGHT;
                    end
                end
                RIGHT: begin
                    if (cnt_q == SLOT_CNT_MAX) begin
                        state_d = SEEK;
                        lost    = 1'b1;
                    end else if (boundary && !ws_s) begin
                        commit  = 1'b1;
                        state_d = LEFT;
                    end
                end
                default: state_d = SEEK;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_ws   <= 1'b0;
            sreg_q    <= '0;
            cnt_q     <= '0;
            left_q    <= '0;
            slot_bits <= '0;
            locked    <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (bit_evt) begin
                prev_ws <= ws_s;
                sreg_q  <= sreg_d;
                cnt_q   <= cnt_d;
            end
            if (latch_left) begin
                left_q <= end_val;
            end
            if (commit) begin
                slot_bits <= end_cnt;
            end
            if (!enable || lost) begin
                locked <= 1'b0;
            end else if (commit) begin
                locked <= 1'b1;
            end
            if (!enable) begin
                overflow <= 1'b0;
            end else if (commit && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign pop = frame.frame_valid && frame.frame_ready;

    i2s_frame_fifo #(
        .WIDTH (2*SW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (commit),
        .pop   (pop),
        .wdata ({left_q, end_val}),
        .rdata (fifo_rdata),
        .level (frame.fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign frame.frame_valid = !fifo_empty;
    assign frame.frame_left  = fifo_rdata[2*SW-1:SW];
    assign frame.frame_right = fifo_rdata[SW-1:0];

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Directed and randomized bench for i2s_rx_stereo.
// Streams are built as slot-aligned bit lists and framed per protocol.
module tb_i2s_rx_stereo;
    import i2s_pkg::*;

    localparam int SW    = 24;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic CLK = 1'b0;
    logic RST;
    logic sck;
    logic ws;
    logic sd;
    logic enable;
    logic mode;
    logic [5:0] slot_bits;
    logic locked;
    logic overflow;

    i2s_rx_stereo_if #(.SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH)) fif ();

    i2s_rx_stereo #(
        .SAMPLE_WIDTH (SW),
        .FIFO_DEPTH   (DEPTH),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .I2S_SCK   (sck),
        .I2S_WS    (ws),
        .I2S_SD    (sd),
        .enable    (enable),
        .mode      (mode),
        .frame     (fif),
        .slot_bits (slot_bits),
        .locked    (locked),
        .overflow  (overflow)
    );

    always #5 CLK = ~CLK;

    int total  = 0;
    int passed = 0;

    bit wq[$];
    bit dq[$];
    logic [SW-1:0] el[$];
    logic [SW-1:0] er[$];
    int  exp_bits;
    bit  exp_ovf;
    int  ready_idx = -1;

    // Keep the top SW bits of a len-bit MSB-first word, zero padded.
    function automatic logic [SW-1:0] expect_val(
        input logic [63:0] v, input int len
    );
        logic [63:0] t;
        if (len >= SW) t = v >> (len - SW);
        else           t = v << (SW - len);
        return t[SW-1:0];
    endfunction

    function automatic logic [63:0] rnd(input int len);
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v & ((64'd1 << len) - 1);
    endfunction

    task automatic chk(
        input string tag, input logic [63:0] obs, input logic [63:0] exp
    );
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic add_slot(input bit w, input int len, input logic [63:0] v);
        for (int i = len - 1; i >= 0; i--) begin
            wq.push_back(w);
            dq.push_back(v[i]);
        end
    endtask

    // One full L/R pair; the model commits it into a bounded queue.
    task automatic add_pair(
        input int len, input logic [63:0] l, input logic [63:0] r
    );
        add_slot(1'b0, len, l);
        add_slot(1'b1, len, r);
        exp_bits = len;
        if (el.size() < DEPTH) begin
            el.push_back(expect_val(l, len));
            er.push_back(expect_val(r, len));
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    task automatic lead_in();
        add_slot(1'b1, 4, 64'h0);
    endtask

    task automatic trailer();
        add_slot(1'b0, 2, 64'h0);
    endtask

    // Philips WS leads the data by one SCK; left-justified is aligned.
    task automatic play();
        for (int i = 0; i < wq.size(); i++) begin
            sck = 1'b0;
            if (mode == I2S_MODE_PHILIPS && i + 1 < wq.size()) ws = wq[i+1];
            else ws = wq[i];
            sd = dq[i];
            repeat (3) @(negedge CLK);
            sck = 1'b1;
            for (int k = 1; k <= 3; k++) begin
                @(negedge CLK);
                if (i == ready_idx) fif.frame_ready = (k == SYNC);
            end
        end
        sck = 1'b0;
        wq.delete();
        dq.delete();
        ready_idx = -1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic restart(input bit m);
        enable = 1'b0;
        repeat (3) @(negedge CLK);
        mode = m;
        repeat (2) @(negedge CLK);
        enable  = 1'b1;
        exp_ovf = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic pop_chk(input string tag);
        chk({tag, ".valid"}, fif.frame_valid, 1);
        chk({tag, ".left"}, fif.frame_left, el[0]);
        chk({tag, ".right"}, fif.frame_right, er[0]);
        void'(el.pop_front());
        void'(er.pop_front());
        fif.frame_ready = 1'b1;
        @(negedge CLK);
        fif.frame_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (el.size() > 0) begin
            pop_chk($sformatf("%s.f%0d", tag, n));
            n++;
        end
        @(negedge CLK);
        chk({tag, ".empty_level"}, fif.fifo_level, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] l5;
        logic [63:0] r5;
        int len;
        RST = 1'b1;
        sck = 1'b0;
        ws = 1'b0;
        sd = 1'b0;
        enable = 1'b0;
        mode = 1'b0;
        fif.frame_ready = 1'b0;
        exp_bits = 0;
        exp_ovf = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst.valid", fif.frame_valid, 0);
        chk("rst.level", fif.fifo_level, 0);
        chk("rst.left", fif.frame_left, 0);
        chk("rst.right", fif.frame_right, 0);
        chk("rst.slot_bits", slot_bits, 0);
        chk("rst.locked", locked, 0);
        chk("rst.overflow", overflow, 0);

        restart(I2S_MODE_PHILIPS);
        lead_in();
        add_pair(32, {40'h0, 24'hA5A5A5} << 8 | rnd(8),
                     {40'h0, 24'h5A5A5A} << 8 | rnd(8));
        trailer();
        play();
        chk("philips.slot_bits", slot_bits, 32);
        chk("philips.locked", locked, 1);
        chk("philips.level", fif.fifo_level, 1);
        drain("philips");

        restart(I2S_MODE_LJ);
        lead_in();
        add_pair(16, 64'h1234, 64'hBEEF);
        trailer();
        play();
        chk("lj.slot_bits", slot_bits, 16);
        chk("lj.left_const", fif.frame_left, 24'h123400);
        drain("lj");

        for (int t = 0; t < 3; t++) begin
            restart(1'($urandom_range(0, 1)));
            lead_in();
            for (int p = 0; p < 3; p++) begin
                len = $urandom_range(8, 40);
                add_pair(len, rnd(len), rnd(len));
            end
            trailer();
            play();
            chk($sformatf("rand%0d.slot_bits", t), slot_bits, exp_bits);
            chk($sformatf("rand%0d.level", t), fif.fifo_level, 3);
            drain($sformatf("rand%0d", t));
        end

        restart(I2S_MODE_PHILIPS);
        lead_in();
        for (int p = 0; p < 6; p++) add_pair(32, rnd(32), rnd(32));
        trailer();
        play();
        chk("ovf.level", fif.fifo_level, DEPTH);
        chk("ovf.overflow", overflow, exp_ovf);
        chk("ovf.locked", locked, 1);
        drain("ovf");
        chk("ovf.sticky", overflow, 1);
        restart(I2S_MODE_PHILIPS);
        chk("ovf.cleared", overflow, 0);

        restart(1'($urandom_range(0, 1)));
        add_slot(1'b0, 10, rnd(10));
        add_slot(1'b1, 20, rnd(20));
        add_pair(24, rnd(24), rnd(24));
        trailer();
        play();
        chk("midslot.level", fif.fifo_level, 1);
        drain("midslot");

        restart(I2S_MODE_PHILIPS);
        lead_in();
        add_pair(32, rnd(32), rnd(32));
        add_slot(1'b0, 70, 64'h0);
        play();
        chk("stuck.locked", locked, 0);
        chk("stuck.level", fif.fifo_level, 1);
        add_slot(1'b1, 32, rnd(32));
        trailer();
        play();
        chk("stuck.relock_level", fif.fifo_level, 1);
        chk("stuck.relock_locked", locked, 0);
        drain("stuck");

        restart(I2S_MODE_PHILIPS);
        lead_in();
        for (int p = 0; p < 4; p++) add_pair(32, rnd(32), rnd(32));
        l5 = rnd(32);
        r5 = rnd(32);
        add_slot(1'b0, 32, l5);
        add_slot(1'b1, 32, r5);
        ready_idx = wq.size() - 1;
        void'(el.pop_front());
        void'(er.pop_front());
        el.push_back(expect_val(l5, 32));
        er.push_back(expect_val(r5, 32));
        trailer();
        play();
        chk("fullpop.level", fif.fifo_level, DEPTH);
        chk("fullpop.overflow", overflow, 0);
        drain("fullpop");

        restart(I2S_MODE_PHILIPS);
        lead_in();
        add_pair(32, rnd(32), rnd(32));
        add_pair(32, rnd(32), rnd(32));
        add_slot(1'b0, 10, rnd(10));
        play();
        chk("rstmid.level_before", fif.fifo_level, 2);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        el.delete();
        er.delete();
        chk("rstmid.valid", fif.frame_valid, 0);
        chk("rstmid.level", fif.fifo_level, 0);
        lead_in();
        add_pair(32, rnd(32), rnd(32));
        trailer();
        play();
        chk("rstmid.new_level", fif.fifo_level, 1);
        chk("rstmid.locked", locked, 1);
        chk("rstmid.slot_bits", slot_bits, 32);
        drain("rstmid");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
